// File: rtl/apu_shared_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apu_shared_arbiter
// Brief    : Round-robin sharing of one APU between NB_CORES cores, with an
//            in-order tag FIFO steering responses back to the issuing core.
// Revision : 1.0
// ============================================================================
module apu_shared_arbiter #(
  parameter int NB_CORES = 4,
  parameter int WOP      = 6,
  parameter int NARGS    = 3,
  parameter int WDATA    = 32,
  parameter int DEPTH    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_CORES-1:0]                 core_req_i,
  input  logic [NB_CORES*WOP-1:0]             core_op_i,
  input  logic [NB_CORES*NARGS*WDATA-1:0]     core_operands_i,
  output logic [NB_CORES-1:0]                 core_gnt_o,
  output logic [NB_CORES-1:0]                 core_valid_o,
  input  logic [NB_CORES-1:0]                 core_ready_i,
  output logic [WDATA-1:0]                    core_result_o,
  output logic                                apu_req_o,
  output logic [WOP-1:0]                      apu_op_o,
  output logic [NARGS*WDATA-1:0]              apu_operands_o,
  input  logic                                apu_gnt_i,
  input  logic                                apu_valid_i,
  input  logic [WDATA-1:0]                    apu_result_i,
  output logic                                apu_ready_o,
  output logic [$clog2(DEPTH+1)-1:0]          outstanding_o,
  output logic                                err_o
);

  localparam int c_PTR_W = $clog2(NB_CORES);
  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_OPS_W = NARGS*WDATA;
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_AW-1:0]    c_LAST_SLOT = c_AW'(DEPTH-1);
  localparam logic [c_PTR_W-1:0] c_LAST_CORE = c_PTR_W'(NB_CORES-1);

  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] r_tag [DEPTH];
  logic [c_AW-1:0]    r_wptr;
  logic [c_AW-1:0]    r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_err;

  logic               w_any;
  logic [c_PTR_W-1:0] w_winner;
  logic [c_PTR_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Scan offsets from the highest down so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [c_PTR_W-1:0] idx;
    w_any    = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = NB_CORES-1; k >= 0; k--) begin
      idx = c_PTR_W'((int'(r_rr_ptr) + k) % NB_CORES);
      if (core_req_i[idx]) begin
        w_any    = 1'b1;
        w_winner = idx;
      end
    end
  end

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag[r_rptr];

  assign apu_req_o      = w_any & ~w_full;
  assign apu_op_o       = w_any ? core_op_i[int'(w_winner)*WOP +: WOP] : '0;
  assign apu_operands_o = w_any ? core_operands_i[int'(w_winner)*c_OPS_W +: c_OPS_W] : '0;
  assign w_push         = apu_req_o & apu_gnt_i;

  assign apu_ready_o   = ~w_empty & core_ready_i[w_head];
  assign w_pop         = apu_valid_i & apu_ready_o;
  assign core_result_o = apu_result_i;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
    assign core_gnt_o[gi]   = w_push & (w_winner == c_PTR_W'(gi));
    assign core_valid_o[gi] = apu_valid_i & ~w_empty & (w_head == c_PTR_W'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_tag    <= '{default: '0};
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= w_winner;
        r_wptr        <= (r_wptr == c_LAST_SLOT) ? '0 : r_wptr + 1'b1;
        r_rr_ptr      <= (w_winner == c_LAST_CORE) ? '0 : w_winner + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_LAST_SLOT) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      // A response with nothing in flight means the APU and this block disagree.
      if (apu_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_shared_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_shared_arbiter
// Brief    : Directed and randomized checks of apu_shared_arbiter against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_apu_shared_arbiter;

  localparam int NB    = 4;
  localparam int WOP   = 6;
  localparam int NARGS = 3;
  localparam int WDATA = 32;
  localparam int DEPTH = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [NB-1:0]               core_req = '0;
  logic [NB*WOP-1:0]           core_op = '0;
  logic [NB*NARGS*WDATA-1:0]   core_operands = '0;
  logic [NB-1:0]               core_ready = '0;
  logic                        apu_gnt = 1'b0;
  logic                        apu_valid = 1'b0;
  logic [WDATA-1:0]            apu_result = '0;

  logic [NB-1:0]               core_gnt_o;
  logic [NB-1:0]               core_valid_o;
  logic [WDATA-1:0]            core_result_o;
  logic                        apu_req_o;
  logic [WOP-1:0]              apu_op_o;
  logic [NARGS*WDATA-1:0]      apu_operands_o;
  logic                        apu_ready_o;
  logic [$clog2(DEPTH+1)-1:0]  outstanding_o;
  logic                        err_o;

  apu_shared_arbiter #(
    .NB_CORES(NB), .WOP(WOP), .NARGS(NARGS), .WDATA(WDATA), .DEPTH(DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_req_i     (core_req),
    .core_op_i      (core_op),
    .core_operands_i(core_operands),
    .core_gnt_o     (core_gnt_o),
    .core_valid_o   (core_valid_o),
    .core_ready_i   (core_ready),
    .core_result_o  (core_result_o),
    .apu_req_o      (apu_req_o),
    .apu_op_o       (apu_op_o),
    .apu_operands_o (apu_operands_o),
    .apu_gnt_i      (apu_gnt),
    .apu_valid_i    (apu_valid),
    .apu_result_i   (apu_result),
    .apu_ready_o    (apu_ready_o),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: issue-order queue of core indices, next-priority core, sticky error.
  int q[$];
  int rr = 0;
  bit err = 1'b0;

  logic [NB-1:0] last_gnt;
  logic [NB-1:0] last_valid;
  logic          last_req;
  logic          last_ready;
  logic          last_err;
  int            last_out;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs currently driven; entered and left at negedge.
  task automatic step();
    int  win;
    int  head;
    bit  any;
    bit  full;
    bit  empty;
    bit  push;
    bit  pop;
    #1;
    any = 1'b0;
    win = 0;
    for (int k = 0; k < NB; k++) begin
      int idx;
      idx = (rr + k) % NB;
      if (!any && core_req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    push  = any && !full && apu_gnt;
    head  = empty ? 0 : q[0];
    pop   = apu_valid && !empty && core_ready[head];

    check("apu_req", apu_req_o, any && !full);
    check("core_gnt", core_gnt_o, push ? (128'd1 << win) : 128'd0);
    check("apu_op", apu_op_o, any ? core_op[win*WOP +: WOP] : '0);
    check("apu_operands", apu_operands_o,
          any ? core_operands[win*NARGS*WDATA +: NARGS*WDATA] : '0);
    check("core_valid", core_valid_o, (apu_valid && !empty) ? (128'd1 << head) : 128'd0);
    check("apu_ready", apu_ready_o, !empty && core_ready[head]);
    check("core_result", core_result_o, apu_result);
    check("outstanding", outstanding_o, q.size());
    check("err", err_o, err);

    last_gnt   = core_gnt_o;
    last_valid = core_valid_o;
    last_req   = apu_req_o;
    last_ready = apu_ready_o;
    last_err   = err_o;
    last_out   = int'(outstanding_o);

    @(posedge clk_i);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(win);
      rr = (win + 1) % NB;
    end
    if (apu_valid && empty) err = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    core_req   = '0;
    core_ready = '0;
    apu_gnt    = 1'b0;
    apu_valid  = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    idle_inputs();
    apu_result = $urandom;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_gnt", core_gnt_o, '0);
    check("rst_valid", core_valid_o, '0);
    check("rst_req", apu_req_o, 1'b0);
    check("rst_op", apu_op_o, '0);
    check("rst_operands", apu_operands_o, '0);
    check("rst_ready", apu_ready_o, 1'b0);
    check("rst_outstanding", outstanding_o, '0);
    check("rst_err", err_o, 1'b0);
    check("rst_result", core_result_o, apu_result);
    @(negedge clk_i);
    rst_ni = 1'b1;
    q.delete();
    rr  = 0;
    err = 1'b0;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NB; i++) core_op[i*WOP +: WOP] = WOP'($urandom);
    for (int i = 0; i < NB*NARGS; i++) core_operands[i*WDATA +: WDATA] = $urandom;
    apu_result = $urandom;
  endtask

  task automatic drain();
    core_req   = '0;
    core_ready = '1;
    apu_valid  = 1'b1;
    for (int i = 0; i < DEPTH + 1 && q.size() > 0; i++) step();
    apu_valid = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      randomize_payload();
      core_req   = NB'($urandom);
      core_ready = NB'($urandom | $urandom);
      apu_gnt    = ($urandom_range(0, 3) != 0);
      apu_valid  = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      step();
    end
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();

    // Single request, answered three cycles later.
    randomize_payload();
    core_op[0 +: WOP] = 6'h05;
    core_req = 4'b0001;
    apu_gnt  = 1'b1;
    step();
    check("t1_gnt", last_gnt, 4'b0001);
    idle_inputs();
    step();
    step();
    check("t1_out", last_out, 1);
    apu_result = 32'hDEADBEEF;
    apu_valid  = 1'b1;
    core_ready = '1;
    step();
    check("t1_valid", last_valid, 4'b0001);
    idle_inputs();
    step();
    check("t1_out_after", last_out, 0);

    // Fill the FIFO with all cores requesting, then drain in order.
    do_reset();
    randomize_payload();
    core_req = '1;
    apu_gnt  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      step();
      check("t2_fill_gnt", last_gnt, 4'b0001 << i);
    end
    step();
    check("t2_full_req", last_req, 1'b0);
    check("t2_full_out", last_out, DEPTH);
    core_req   = '0;
    apu_valid  = 1'b1;
    core_ready = '1;
    for (int i = 0; i < NB; i++) begin
      step();
      check("t2_resp_valid", last_valid, 4'b0001 << i);
    end
    idle_inputs();

    // Round robin starting from pointer 2 with cores 0 and 3 requesting.
    do_reset();
    randomize_payload();
    core_req = 4'b0010;
    apu_gnt  = 1'b1;
    step();
    core_req = 4'b1001;
    step();
    check("t3_first", last_gnt, 4'b1000);
    step();
    check("t3_second", last_gnt, 4'b0001);
    core_req = 4'b1111;
    step();
    check("t3_rr_after", last_gnt, 4'b0010);
    drain();

    // Request backpressure, then response backpressure on the head core.
    do_reset();
    randomize_payload();
    core_req = 4'b0010;
    apu_gnt  = 1'b0;
    for (int i = 0; i < 5; i++) step();
    apu_gnt = 1'b1;
    step();
    check("t4_gnt_release", last_gnt, 4'b0010);
    core_req   = '0;
    apu_valid  = 1'b1;
    core_ready = 4'b1101;
    step();
    step();
    check("t5_ready_low", last_ready, 1'b0);
    core_ready = 4'b0010;
    step();
    check("t5_ready_high", last_ready, 1'b1);
    idle_inputs();
    step();
    check("t5_popped", last_out, 0);

    // Boundary events: push+pop at count 2, full with pop, response when empty.
    do_reset();
    randomize_payload();
    core_req = 4'b0011;
    apu_gnt  = 1'b1;
    step();
    step();
    core_req   = 4'b0100;
    apu_valid  = 1'b1;
    core_ready = '1;
    step();
    check("t6_pushpop_count_before", last_out, 2);
    apu_valid = 1'b0;
    core_req  = 4'b1000;
    step();
    check("t6_pushpop_count_after", last_out, 2);
    core_req = 4'b0001;
    step();
    core_req  = '1;
    apu_valid = 1'b1;
    step();
    check("t6_full_pop_gnt", last_gnt, 4'b0000);
    drain();
    apu_valid = 1'b1;
    step();
    idle_inputs();
    step();
    check("t6_err_set", last_err, 1'b1);
    step();
    check("t6_err_sticky", last_err, 1'b1);

    // Randomized traffic with an asynchronous reset in the middle.
    do_reset();
    random_phase(400);
    do_reset();
    random_phase(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apu_shared_arbiter.md
# apu_shared_arbiter

Shares one APU/FPU instance between `NB_CORES` cluster cores. Each core's dispatcher talks to it over the req/gnt request and valid/ready response handshake. The block arbitrates requests round-robin, forwards the winning operation to the shared APU, and records the issuing core index in an in-order tag FIFO. Each APU response is steered back to the core at the FIFO head. It sits between the per-core APU dispatchers and the shared APU in the cluster.

## Interface
- `NB_CORES`, 4: number of requesting cores, ≥2.
- `WOP`, 6: operation/opcode width.
- `NARGS`, 3: operands per request.
- `WDATA`, 32: operand/result width.
- `DEPTH`, 4: maximum outstanding requests (tag FIFO depth), ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `core_req_i`  in  NB_CORES  per-core request.
- `core_op_i`  in  NB_CORES×WOP  per-core opcode.
- `core_operands_i`  in  NB_CORES×NARGS×WDATA  per-core operands.
- `core_gnt_o`  out  NB_CORES  one-hot grant.
- `core_valid_o`  out  NB_CORES  one-hot response valid.
- `core_ready_i`  in  NB_CORES  per-core response ready.
- `core_result_o`  out  WDATA  result, broadcast to all cores.
- `apu_req_o`  out  1  request to the APU.
- `apu_op_o`  out  WOP  opcode of the winning core.
- `apu_operands_o`  out  NARGS×WDATA  operands of the winning core.
- `apu_gnt_i`  in  1  APU accepts the request.
- `apu_valid_i`  in  1  APU response valid.
- `apu_result_i`  in  WDATA  APU result.
- `apu_ready_o`  out  1  response accepted.
- `outstanding_o`  out  $clog2(DEPTH+1)  count of in-flight requests.
- `err_o`  out  1  sticky: response received while the FIFO was empty.

## Operation
- **State:** `rr_ptr` (round-robin pointer, $clog2(NB_CORES) bits); tag FIFO of core indices with `DEPTH` entries, wrapping read/write pointers and a count; `err` flag.
- **Arbitration:**
  - The winner is the first core i with `core_req_i[i]`=1, scanning from `rr_ptr` upward and wrapping modulo `NB_CORES`.
  - `apu_op_o` and `apu_operands_o` are muxed from the winner. They are 0 when no core requests.
- **APU request:** `apu_req_o` = any request & FIFO not full. When the FIFO is full no request is issued, even if a pop occurs in the same cycle.
- **Issue:** when `apu_req_o` & `apu_gnt_i`:
  - `core_gnt_o[winner]`=1 and all other grant bits are 0.
  - The winner index is pushed into the FIFO.
  - `rr_ptr` <= (winner+1) mod `NB_CORES`.
  - Without `apu_gnt_i`, `rr_ptr` is held. The same winner is presented again next cycle unless its request drops.
- **Response:**
  - head = FIFO read entry.
  - `core_valid_o[head]` = `apu_valid_i` & FIFO not empty.
  - `core_result_o` = `apu_result_i`.
  - `apu_ready_o` = FIFO not empty & `core_ready_i[head]`.
  - Pop when `apu_valid_i` & `apu_ready_o`.
- **Ordering:** the APU returns responses in issue order. A request is never answered in its own issue cycle, because APU latency is ≥1.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Unexpected response:** `apu_valid_i` with an empty FIFO sets `err` (sticky until reset). No `core_valid_o` bit asserts and `apu_ready_o`=0.
- **Reset (async, mid-operation):**
  - FIFO is cleared, `rr_ptr`=0, `err`=0, and in-flight requests are dropped.
  - Output values at reset: all grant/valid outputs 0, `apu_req_o`=0, `apu_op_o`/`apu_operands_o`=0 (no requests), `apu_ready_o`=0, `outstanding_o`=0, `err_o`=0, `core_result_o`=`apu_result_i`.

## Timing
- Grant path is combinational: `core_req_i` → `apu_req_o` → `apu_gnt_i` → `core_gnt_o` in the same cycle.
- Response steering is combinational from `apu_valid_i` in the same cycle.
- FIFO pointers, `outstanding_o`, `rr_ptr` and `err_o` update on the rising edge after the event.
- Throughput: one issue and one response per cycle at steady state.
- Fairness: a continuously requesting core waits at most `NB_CORES`-1 grants.

## Test plan
1. **Single request.** Core 0 requests op 0x05, `apu_gnt_i`=1; `apu_valid_i` with 0xDEADBEEF three cycles later.
   - Required: `core_gnt_o`=0001; `outstanding_o` 0→1.
   - At the response: `core_valid_o`=0001, `core_result_o`=0xDEADBEEF, `outstanding_o` returns to 0.
2. **Fill.** All four cores request continuously, `apu_gnt_i`=1, no responses (`DEPTH`=4).
   - Required: grants 0,1,2,3 on consecutive cycles, then `apu_req_o`=0 with `outstanding_o`=4.
   - Responses then route to cores 0,1,2,3 in order.
3. **Round-robin.** `rr_ptr`=2; cores 0 and 3 request.
   - Required: core 3 granted first, core 0 next, `rr_ptr`=1 afterwards.
4. **Request backpressure.** `apu_gnt_i`=0 for 5 cycles with core 1 requesting.
   - Required: no `core_gnt_o`; `apu_op_o`/`apu_operands_o` stable at core 1 values; `rr_ptr` unchanged.
5. **Response backpressure.** Head core has `core_ready_i`=0 while `apu_valid_i`=1.
   - Required: `apu_ready_o`=0 and no pop; pop occurs on the cycle ready rises.
6. **Boundary events.**
   - Push and pop in the same cycle at count 2: count stays 2.
   - Full FIFO with a pop that cycle: no grant.
   - `apu_valid_i` with an empty FIFO: `err_o`=1 from the next cycle until reset.
